// File: rtl/bsg_level_shift_up_down_seq.sv
// Power-domain isolation gate: after a settle interval it opens channels one per cycle,
// and clamps every channel at once on de-request (next edge) or power loss (same cycle).
module bsg_level_shift_up_down_seq #(
    parameter int unsigned width_p         = 128,
    parameter int unsigned els_p           = 4,
    parameter int unsigned settle_cycles_p = 4,
    parameter int unsigned clamp_mode_p    = 0
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       en_req_i,
    input  logic                       pwr_good_i,
    input  logic [els_p*width_p-1:0]   v0_data_i,
    output logic [els_p*width_p-1:0]   v1_data_o,
    output logic [els_p-1:0]           chan_en_o,
    output logic                       active_o,
    output logic                       busy_o
);

    localparam int unsigned CNT_W = $clog2(settle_cycles_p + 1);
    localparam int unsigned IDX_W = $clog2(els_p + 1);
    localparam int unsigned DW    = els_p * width_p;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_OPEN,
        S_ACTIVE
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [els_p-1:0]   chan_en_q;
    logic               active_q;
    logic               busy_q;
    logic [DW-1:0]      hold_q;
    logic [els_p-1:0]   open_c;
    logic               abort_c;

    assign abort_c = ~en_req_i | ~pwr_good_i;

    // Power loss and reset close channels without waiting for an edge.
    assign open_c = chan_en_q & {els_p{pwr_good_i & ~reset_i}};

    // Sequencer: abort outranks every transition except reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            chan_en_q <= '0;
            active_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else if (state_q != S_IDLE && abort_c) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            chan_en_q <= '0;
            active_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en_req_i & pwr_good_i) begin
                        state_q <= S_SETTLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == CNT_W'(settle_cycles_p - 1)) begin
                        state_q <= S_OPEN;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_OPEN: begin
                    chan_en_q <= chan_en_q | (els_p'(1) << idx_q);
                    idx_q     <= idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(els_p - 1)) begin
                        state_q  <= S_ACTIVE;
                        active_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                end
                S_ACTIVE: begin
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Last value seen through each open channel, used by the hold clamp.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hold_q <= '0;
        end else begin
            for (int c = 0; c < int'(els_p); c++) begin
                if (open_c[c]) begin
                    hold_q[c*width_p +: width_p] <= v0_data_i[c*width_p +: width_p];
                end
            end
        end
    end

    always_comb begin
        v1_data_o = '0;
        for (int c = 0; c < int'(els_p); c++) begin
            if (open_c[c]) begin
                v1_data_o[c*width_p +: width_p] = v0_data_i[c*width_p +: width_p];
            end else if (clamp_mode_p == 1) begin
                v1_data_o[c*width_p +: width_p] = '1;
            end else if (clamp_mode_p == 2) begin
                v1_data_o[c*width_p +: width_p] = hold_q[c*width_p +: width_p];
            end else begin
                v1_data_o[c*width_p +: width_p] = '0;
            end
        end
    end

    assign chan_en_o = chan_en_q;
    assign active_o  = active_q;
    assign busy_o    = busy_q;

endmodule
